// File: rtl/sht30_pkg.sv
// Shared types and constants for the SHT30 sensor emulator.
package sht30_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        CMD_HI,
        ACK1,
        CMD_LO,
        ACK2,
        TX_BYTE,
        M_ACK,
        IGNORE
    } state_t;

    localparam logic [15:0] CMD_MEAS       = 16'h2400;
    localparam logic [15:0] CMD_SOFT_RESET = 16'h30A2;

    localparam logic [7:0]  CRC_POLY = 8'h31;
    localparam logic [7:0]  CRC_INIT = 8'hFF;

endpackage

// File: rtl/sht30_crc8.sv
// Sensirion CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR)
// over a 16-bit word, MSB byte first.
module sht30_crc8
    import sht30_pkg::*;
(
    input  logic [15:0] data,
    output logic [7:0]  crc
);

    // Bit-serial CRC unrolled across all 16 data bits.
    always_comb begin
        logic [7:0] c;
        c = CRC_INIT;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ CRC_POLY;
            else                c = {c[6:0], 1'b0};
        end
        crc = c;
    end

endmodule

// File: rtl/sht30_responder.sv
// I2C slave emulating an SHT30: accepts a 16-bit command, and after the
// measurement command returns temp MSB/LSB/CRC, hum MSB/LSB/CRC.
module sht30_responder #(
    parameter logic [6:0]  I2C_ADDR    = 7'h44,
    parameter logic [15:0] CMD_MEAS    = 16'h2400,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_raw,
    input  logic [15:0] hum_raw,
    output logic        cmd_valid,
    output logic [15:0] cmd,
    output logic        meas_pending,
    output logic        bus_busy
);
    import sht30_pkg::*;

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [SS-1:0] scl_sync, sda_sync;
    logic          scl_q, sda_q, scl_s, sda_s;
    logic          scl_rise, scl_fall, start_c, stop_c;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  sh, sh_n, cmd_hi, hi_n;
    logic [2:0]  idx, idx_n;
    logic        mack, mack_n, oe_n, cv_n, pend_n, busy_n, snap;
    logic [15:0] cmd_n, t_snap, h_snap;
    logic [7:0]  crc_t, crc_h, crc_t_w, crc_h_w, tx_cur, tx_next;
    logic [47:0] buf_flat;

    sht30_crc8 u_crc_t (.data(temp_raw), .crc(crc_t_w));
    sht30_crc8 u_crc_h (.data(hum_raw),  .crc(crc_h_w));

    function automatic logic [7:0] pick(input logic [47:0] b, input logic [2:0] i);
        case (i)
            3'd0:    return b[47:40];
            3'd1:    return b[39:32];
            3'd2:    return b[31:24];
            3'd3:    return b[23:16];
            3'd4:    return b[15:8];
            default: return b[7:0];
        endcase
    endfunction

    // Synchronizers plus one extra sample for edge detection; idle bus = 1.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SS-2:0], scl_in};
            sda_sync <= {sda_sync[SS-2:0], sda_in};
            scl_q    <= scl_sync[SS-1];
            sda_q    <= sda_sync[SS-1];
        end
    end

    assign scl_s    = scl_sync[SS-1];
    assign sda_s    = sda_sync[SS-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    // SCL must be stable high in both samples, so a simultaneous change is an SCL edge only.
    assign start_c  = scl_s & scl_q & ~sda_s & sda_q;
    assign stop_c   = scl_s & scl_q & sda_s & ~sda_q;

    assign buf_flat = {t_snap, crc_t, h_snap, crc_h};
    assign tx_cur   = pick(buf_flat, idx);
    assign tx_next  = pick(buf_flat, idx + 3'd1);

    // Protocol FSM: START/STOP take priority over bit handling.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        hi_n    = cmd_hi;
        idx_n   = idx;
        mack_n  = mack;
        oe_n    = sda_oe;
        cv_n    = 1'b0;
        cmd_n   = cmd;
        pend_n  = meas_pending;
        busy_n  = bus_busy;
        snap    = 1'b0;
        if (stop_c) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start_c) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state)
                ADDR, CMD_HI, CMD_LO: begin
                    if (scl_rise && cnt < 4'd8) begin
                        sh_n  = {sh[6:0], sda_s};
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall && cnt == 4'd8) begin
                        cnt_n = 4'd0;
                        case (state)
                            ADDR: begin
                                if (sh[7:1] == I2C_ADDR && (!sh[0] || meas_pending)) begin
                                    state_n = ADDR_ACK;
                                    oe_n    = 1'b1;
                                end else begin
                                    state_n = IGNORE;
                                end
                            end
                            CMD_HI: begin
                                hi_n    = sh;
                                state_n = ACK1;
                                oe_n    = 1'b1;
                            end
                            default: begin
                                state_n = ACK2;
                                oe_n    = 1'b1;
                            end
                        endcase
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    // sh still holds the address byte; its LSB selects read or write.
                    if (sh[0]) begin
                        state_n = TX_BYTE;
                        idx_n   = 3'd0;
                        cnt_n   = 4'd1;
                        oe_n    = ~t_snap[15];
                    end else begin
                        state_n = CMD_HI;
                        oe_n    = 1'b0;
                    end
                end
                ACK1: if (scl_fall) begin
                    state_n = CMD_LO;
                    oe_n    = 1'b0;
                end
                ACK2: if (scl_fall) begin
                    state_n = IGNORE;
                    oe_n    = 1'b0;
                    cv_n    = 1'b1;
                    cmd_n   = {cmd_hi, sh};
                    if ({cmd_hi, sh} == CMD_MEAS) begin
                        pend_n = 1'b1;
                        snap   = 1'b1;
                    end else if ({cmd_hi, sh} == CMD_SOFT_RESET) begin
                        pend_n = 1'b0;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        state_n = M_ACK;
                        oe_n    = 1'b0;
                        if (idx == 3'd5) pend_n = 1'b0;
                    end else begin
                        oe_n  = ~tx_cur[3'd7 - cnt[2:0]];
                        cnt_n = cnt + 4'd1;
                    end
                end
                M_ACK: begin
                    if (scl_rise) begin
                        mack_n = sda_s;
                    end else if (scl_fall) begin
                        if (!mack && idx != 3'd5) begin
                            state_n = TX_BYTE;
                            idx_n   = idx + 3'd1;
                            cnt_n   = 4'd1;
                            oe_n    = ~tx_next[7];
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                default: oe_n = 1'b0;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            sh           <= 8'h00;
            cmd_hi       <= 8'h00;
            idx          <= 3'd0;
            mack         <= 1'b1;
            sda_oe       <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd          <= 16'h0000;
            meas_pending <= 1'b0;
            bus_busy     <= 1'b0;
            t_snap       <= 16'h0000;
            h_snap       <= 16'h0000;
            crc_t        <= 8'h00;
            crc_h        <= 8'h00;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sh           <= sh_n;
            cmd_hi       <= hi_n;
            idx          <= idx_n;
            mack         <= mack_n;
            sda_oe       <= oe_n;
            cmd_valid    <= cv_n;
            cmd          <= cmd_n;
            meas_pending <= pend_n;
            bus_busy     <= busy_n;
            if (snap) begin
                t_snap <= temp_raw;
                h_snap <= hum_raw;
                crc_t  <= crc_t_w;
                crc_h  <= crc_h_w;
            end
        end
    end

endmodule

// File: tb/tb_sht30_responder.sv
// Bench for sht30_responder: bit-level I2C master, scoreboards for bus
// bytes/ACKs and for cmd_valid pulses.
module tb_sht30_responder;

    logic        clk_50M = 1'b0;
    logic        rst, scl_m, sda_m, sda_bus;
    logic [15:0] temp_raw, hum_raw, cmd;
    logic        sda_oe, cmd_valid, meas_pending, bus_busy;

    always #10 clk_50M = ~clk_50M;

    // Open-drain bus: either side can pull SDA low.
    assign sda_bus = sda_m & ~sda_oe;

    sht30_responder dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .scl_in       (scl_m),
        .sda_in       (sda_bus),
        .sda_oe       (sda_oe),
        .temp_raw     (temp_raw),
        .hum_raw      (hum_raw),
        .cmd_valid    (cmd_valid),
        .cmd          (cmd),
        .meas_pending (meas_pending),
        .bus_busy     (bus_busy)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  obs_q[$];
    logic [15:0] exp_cmd_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        oe_seen = 1'b0;
    exp_t        mon_e;
    logic [7:0]  mon_o;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: compare every observed ACK bit / data byte in order.
    always @(negedge clk_50M) begin
        while (obs_q.size() > 0) begin
            mon_o = obs_q.pop_front();
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus: unexpected observation %h, none expected", mon_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk(mon_e.name, {8'h00, mon_o}, {8'h00, mon_e.val});
            end
        end
    end

    // Command monitor: every cmd_valid pulse must match a queued command.
    always @(negedge clk_50M) begin
        if (cmd_valid === 1'b1) begin
            if (exp_cmd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cmd_valid: unexpected pulse with cmd=%h, none expected", cmd);
            end else begin
                chk("cmd on cmd_valid", cmd, exp_cmd_q.pop_front());
            end
        end
    end

    // Records any SDA drive by the responder.
    always @(negedge clk_50M) if (sda_oe === 1'b1) oe_seen = 1'b1;

    task automatic qw;
        repeat (10) @(negedge clk_50M);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b0; qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; qw();
        scl_m = 1'b1; qw();
        sda_m = 1'b1; qw();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    qw();
        scl_m = 1'b1; qw(); qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        b = sda_bus;  qw();
        scl_m = 1'b0; qw();
    endtask

    task automatic wr(input logic [7:0] b, input logic exp_ack, input string nm);
        logic a;
        exp_q.push_back('{name: nm, val: {7'd0, exp_ack}});
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(a);
        obs_q.push_back({7'd0, a});
    endtask

    task automatic rd(input logic [7:0] exp_b, input logic ack, input string nm);
        logic [7:0] v;
        logic       b;
        exp_q.push_back('{name: nm, val: exp_b});
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        obs_q.push_back(v);
        put_bit(ack);
    endtask

    task automatic write_cmd(input logic [15:0] c);
        exp_cmd_q.push_back(c);
        i2c_start();
        wr(8'h88, 1'b0, "write addr ack");
        wr(c[15:8], 1'b0, "cmd hi ack");
        wr(c[7:0], 1'b0, "cmd lo ack");
        i2c_stop();
    endtask

    // Full 6-byte read: master ACKs five bytes and NACKs the last.
    task automatic read6(input logic [47:0] e);
        i2c_start();
        wr(8'h89, 1'b0, "read addr ack");
        for (int i = 0; i < 6; i++)
            rd(e[47-8*i -: 8], (i == 5), "read byte");
        chk("meas_pending after byte 6", {15'd0, meas_pending}, 16'd0);
        i2c_stop();
    endtask

    initial begin
        logic b;
        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        temp_raw = 16'hBEEF; hum_raw = 16'hBEEF;
        repeat (5) @(negedge clk_50M);
        chk("reset sda_oe", {15'd0, sda_oe}, 16'd0);
        chk("reset cmd_valid", {15'd0, cmd_valid}, 16'd0);
        chk("reset cmd", cmd, 16'h0000);
        chk("reset meas_pending", {15'd0, meas_pending}, 16'd0);
        chk("reset bus_busy", {15'd0, bus_busy}, 16'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk_50M);

        // Measurement command write.
        exp_cmd_q.push_back(16'h2400);
        i2c_start();
        chk("bus_busy after START", {15'd0, bus_busy}, 16'd1);
        wr(8'h88, 1'b0, "write addr ack");
        wr(8'h24, 1'b0, "cmd hi ack");
        wr(8'h00, 1'b0, "cmd lo ack");
        i2c_stop();
        chk("cmd after write", cmd, 16'h2400);
        chk("meas_pending after CMD_MEAS", {15'd0, meas_pending}, 16'd1);
        chk("bus_busy after STOP", {15'd0, bus_busy}, 16'd0);

        // Full read of BEEF/BEEF: CRC(BE EF) = 0x92.
        read6(48'hBEEF92_BEEF92);

        // Read with nothing pending: NACK, no drive at all.
        oe_seen = 1'b0;
        i2c_start();
        wr(8'h89, 1'b1, "read addr nack");
        rd(8'hFF, 1'b1, "released bus byte");
        chk("no sda drive on nacked read", {15'd0, oe_seen}, 16'd0);
        i2c_stop();

        // Foreign address.
        i2c_start();
        wr(8'h90, 1'b1, "foreign addr nack");
        wr(8'h24, 1'b1, "foreign data nack");
        chk("bus_busy during foreign xfer", {15'd0, bus_busy}, 16'd1);
        i2c_stop();
        chk("bus_busy after foreign STOP", {15'd0, bus_busy}, 16'd0);
        chk("cmd unchanged by foreign xfer", cmd, 16'h2400);

        // Snapshot then partial read: CRC(00 00) = 0x81.
        temp_raw = 16'h0000; hum_raw = 16'hBEEF;
        write_cmd(16'h2400);
        temp_raw = 16'h1234; hum_raw = 16'h5678;
        i2c_start();
        wr(8'h89, 1'b0, "partial read addr ack");
        rd(8'h00, 1'b0, "partial byte 0");
        rd(8'h00, 1'b1, "partial byte 1");
        i2c_stop();
        chk("meas_pending after partial read", {15'd0, meas_pending}, 16'd1);
        read6(48'h000081_BEEF92);

        // Repeated START mid-command: no cmd_valid, cmd unchanged.
        temp_raw = 16'hBEEF; hum_raw = 16'hBEEF;
        write_cmd(16'h2400);
        i2c_start();
        wr(8'h88, 1'b0, "rs addr ack");
        wr(8'h30, 1'b0, "rs cmd hi ack");
        i2c_start();
        wr(8'h88, 1'b0, "rs readdress ack");
        i2c_stop();
        chk("cmd after repeated START", cmd, 16'h2400);
        chk("meas_pending after repeated START", {15'd0, meas_pending}, 16'd1);

        // Soft reset command clears the pending measurement.
        write_cmd(16'h30A2);
        chk("meas_pending after soft reset", {15'd0, meas_pending}, 16'd0);

        // Reset during bit 4 of TX byte 1 (0xEF: that bit is 0, so SDA is driven).
        write_cmd(16'h2400);
        i2c_start();
        wr(8'h89, 1'b0, "rst read addr ack");
        rd(8'hBE, 1'b0, "rst byte 0");
        for (int i = 0; i < 3; i++) get_bit(b);
        sda_m = 1'b1; qw();
        scl_m = 1'b1; qw();
        chk("sda_oe driving bit 4", {15'd0, sda_oe}, 16'd1);
        rst = 1'b1;
        @(negedge clk_50M);
        rst = 1'b0;
        chk("sda_oe after rst", {15'd0, sda_oe}, 16'd0);
        chk("meas_pending after rst", {15'd0, meas_pending}, 16'd0);
        chk("bus_busy after rst", {15'd0, bus_busy}, 16'd0);
        scl_m = 1'b0; qw();
        i2c_stop();
        i2c_start();
        wr(8'h89, 1'b1, "read after rst nack");
        i2c_stop();

        repeat (20) @(negedge clk_50M);
        chk("bus scoreboard drained", 16'(exp_q.size()), 16'd0);
        chk("cmd scoreboard drained", 16'(exp_cmd_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sht30_responder.md
Name: sht30_responder

Overview:
- Synthesizable I2C slave that emulates the SHT30 humidity/temperature sensor. It is the responder at the other end of the bus driven by the team's I2C master, which is clocked from the 50 kHz SCL timebase.
- Oversamples SCL/SDA on clk_50M, accepts the single-shot measurement command, and returns 6 bytes: temperature MSB, temperature LSB, CRC, humidity MSB, humidity LSB, CRC.
- Used for board-level loopback tests and as a sensor stand-in.

Parameters:
- I2C_ADDR, 7'h44, 7-bit slave address.
- CMD_MEAS, 16'h2400, measurement command that arms the read-back.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  bus SCL level (asynchronous).
- sda_in  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- temp_raw  in  16  temperature word to report.
- hum_raw  in  16  humidity word to report.
- cmd_valid  out  1  one-cycle pulse when any 16-bit command is fully received and ACKed.
- cmd  out  16  last received command; held until the next one.
- meas_pending  out  1  a CMD_MEAS was received and its data has not yet been read.
- bus_busy  out  1  high from START to STOP.

Behaviour:
- Reset: sda_oe=0, cmd_valid=0, cmd=16'h0000, meas_pending=0, bus_busy=0, FSM=IDLE. Synchronizer flops reset to 1 (idle bus).
- Sync/edges:
  - SCL rise/fall and SDA rise/fall are detected on synchronized samples.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are evaluated before bit logic.
- Bit timing:
  - Sample SDA on SCL rising edge.
  - Change sda_oe only on SCL falling edge: at most 1 cycle after the synchronized fall, with no glitch while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, CMD_HI, ACK1, CMD_LO, ACK2, TX_BYTE, M_ACK, IGNORE.
- IDLE --START--> ADDR. A START in any state (repeated START) --> ADDR. STOP in any state --> IDLE with sda_oe released.
- ADDR: shift in 8 bits, MSB first.
  - {I2C_ADDR,0} --> ADDR_ACK, then CMD_HI.
  - {I2C_ADDR,1} with meas_pending=1 --> ADDR_ACK, then TX_BYTE with byte index 0.
  - {I2C_ADDR,1} with meas_pending=0 --> NACK (SDA released), then IGNORE.
  - Address mismatch --> IGNORE, no ACK.
- ACK phase: sda_oe=1 from the 8th SCL fall to the 9th SCL fall.
- CMD_HI, ACK1, CMD_LO, ACK2: ACK both command bytes.
  - At the 9th fall of ACK2: cmd<={hi,lo}, cmd_valid pulse, then IGNORE.
  - If {hi,lo}==CMD_MEAS: snapshot temp_raw/hum_raw and compute both CRCs into a 6-byte buffer; meas_pending<=1.
  - A new CMD_MEAS while pending re-snapshots the data.
- TX_BYTE: drive the buffer byte MSB first, sda_oe = ~bit, updated on SCL falls. The first bit is driven on the fall that ends the address ACK.
- M_ACK: release SDA and sample the master bit on SCL rise.
  - ACK (0) and index<5 --> next byte.
  - NACK, or index==5 --> IGNORE.
  - meas_pending clears when byte index 5 has been shifted out, whether ACKed or not. A partial read leaves it set.
- IGNORE: sda_oe=0 until START or STOP.
- CRC: CRC-8 over the MSB then LSB byte, polynomial 0x31, init 0xFF, no reflection, no final XOR.
- Reset mid-transfer: immediate return to the reset state; any pending measurement is lost.
- Simultaneous SCL and SDA change in the same synchronized sample: no START/STOP; treat as an SCL edge only.

Decomposition:
- Package sht30_pkg holds:
  - FSM state enum.
  - Command constants: CMD_MEAS, plus CMD_SOFT_RESET 16'h30A2, which is ACKed and clears meas_pending.
  - CRC_POLY 8'h31 and CRC_INIT 8'hFF.
- One combinational sub-module, sht30_crc8: 16-bit word in, 8-bit CRC out. Instantiated twice.

Test Plan:
- Write 0x88, 0x24, 0x00, STOP -> three ACKs; cmd_valid pulses once; cmd=16'h2400; meas_pending=1.
- temp_raw=16'hBEEF, hum_raw=16'hBEEF, write CMD_MEAS, then read 0x89 with 6 bytes (master ACKs 5, NACKs the last) -> bytes BE EF 92 BE EF 92; meas_pending=0 after byte 6.
- Read 0x89 with no pending measurement -> address NACK (SDA high at 9th clock); sda_oe stays 0 until STOP.
- Address 0x90 write -> no ACK; cmd unchanged; bus_busy high until STOP, then 0.
- Read aborted after 2 bytes via master NACK, then STOP -> meas_pending stays 1; a second read returns the same 6 bytes.
- rst asserted during the 4th bit of TX byte 1 -> next cycle sda_oe=0 and meas_pending=0; a subsequent read 0x89 is NACKed. Also cover a repeated START mid-command: restarts address decode, no cmd_valid pulse.
